// File: rtl/cpu_di_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_di_pkg
//  Brief    : Shared types and helpers for the Z80 DI-bus multiplexer
//             (state encoding, floating-bus value, lowest-set-bit search).
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_di_pkg;

  // FSM encoding for the read sequencer
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Value seen on an undriven Z80 data bus
  localparam logic [7:0] DEFAULT_DATA_C = 8'hFF;

  // Widest select vector the helper below can search
  localparam int MAX_CH_C = 32;

  // Index of the lowest set bit; returns 0 for an all-zero vector
  function automatic int lowest_set_idx(input logic [MAX_CH_C-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_CH_C - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/di_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : di_prio_enc
//  Brief    : Fixed-priority encoder over the per-channel select lines.
//             Lowest index wins. multi_o flags more than one active select
//             and is only built when CPU_DI_COLLISION_DET_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module di_prio_enc
  import cpu_di_pkg::*;
#(
  parameter int NUM_CH = 4
)(
  input  logic [NUM_CH-1:0]         ch_sel_i,
  output logic                      any_o,
  output logic [$clog2(NUM_CH)-1:0] idx_o,
  output logic                      multi_o
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [MAX_CH_C-1:0] w_sel_ext;

  // Zero-extend the selects and pick the lowest asserted channel
  always_comb begin
    w_sel_ext               = '0;
    w_sel_ext[NUM_CH-1:0]   = ch_sel_i;
    idx_o                   = IDX_W'(lowest_set_idx(w_sel_ext));
  end

  assign any_o = |ch_sel_i;

`ifdef CPU_DI_COLLISION_DET_EN
  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi_o = |(ch_sel_i & (ch_sel_i - NUM_CH'(1)));
`else
  assign multi_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/cpu_di_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_di_mux_n
//  Brief    : N-channel Z80 data-input multiplexer with registered output,
//             per-channel programmable WAIT insertion and data hold until
//             the read strobe ends. Sole driver of the CPU DI bus.
//             Optional sticky collision flag: CPU_DI_COLLISION_DET_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_di_mux_n
  import cpu_di_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                DATA_W       = 8,
  parameter int                WAIT_W       = 4,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(DEFAULT_DATA_C)
)(
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data_i,
  input  logic [NUM_CH-1:0]         ch_sel_i,
  input  logic [NUM_CH*WAIT_W-1:0]  ch_wait_i,
  input  logic                      cpu_rd_n_i,
  input  logic                      collision_clr_i,
  output logic [DATA_W-1:0]         cpu_di_o,
  output logic                      cpu_wait_n_o,
  output logic                      busy_o,
  output logic [$clog2(NUM_CH)-1:0] active_ch_o,
  output logic                      collision_o
);

  localparam int                IDX_W     = $clog2(NUM_CH);
  localparam logic [WAIT_W-1:0] c_cnt_one = WAIT_W'(1);

  state_e              r_state_q,  w_state_d;
  logic [WAIT_W-1:0]   r_cnt_q,    w_cnt_d;
  logic [DATA_W-1:0]   r_di_q,     w_di_d;
  logic                r_wait_n_q, w_wait_n_d;
  logic [IDX_W-1:0]    r_ch_q,     w_ch_d;

  logic                w_any;
  logic [IDX_W-1:0]    w_idx;
  logic                w_multi;
  logic                w_start;
  logic [WAIT_W-1:0]   w_start_wait;
  logic [DATA_W-1:0]   w_start_data;
  logic [DATA_W-1:0]   w_held_data;

  di_prio_enc #(
    .NUM_CH (NUM_CH)
  ) u_prio_enc (
    .ch_sel_i (ch_sel_i),
    .any_o    (w_any),
    .idx_o    (w_idx),
    .multi_o  (w_multi)
  );

  // Candidate grant is taken from the live selects; once granted, data comes
  // from the locked channel so later select changes have no effect.
  assign w_start      = ~cpu_rd_n_i & w_any;
  assign w_start_wait = ch_wait_i[w_idx * WAIT_W +: WAIT_W];
  assign w_start_data = ch_data_i[w_idx * DATA_W +: DATA_W];
  assign w_held_data  = ch_data_i[r_ch_q * DATA_W +: DATA_W];

  // State, counter, grant and output registers; reset releases WAIT at once
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state_q  <= ST_IDLE;
      r_cnt_q    <= '0;
      r_di_q     <= DEFAULT_DATA;
      r_wait_n_q <= 1'b1;
      r_ch_q     <= '0;
    end else begin
      r_state_q  <= w_state_d;
      r_cnt_q    <= w_cnt_d;
      r_di_q     <= w_di_d;
      r_wait_n_q <= w_wait_n_d;
      r_ch_q     <= w_ch_d;
    end
  end

  // Next-state: start only from IDLE, strobe release always returns to IDLE
  always_comb begin
    w_state_d = r_state_q;
    case (r_state_q)
      ST_IDLE: begin
        if (w_start) w_state_d = (w_start_wait == '0) ? ST_HOLD : ST_WAIT;
      end
      ST_WAIT: begin
        if (cpu_rd_n_i)                w_state_d = ST_IDLE;
        else if (r_cnt_q == c_cnt_one) w_state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cpu_rd_n_i) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: grant latch, wait countdown, data capture/release
  always_comb begin
    w_cnt_d    = r_cnt_q;
    w_di_d     = r_di_q;
    w_wait_n_d = r_wait_n_q;
    w_ch_d     = r_ch_q;
    case (r_state_q)
      ST_IDLE: begin
        if (w_start) begin
          w_ch_d = w_idx;
          if (w_start_wait == '0) begin
            w_di_d = w_start_data;
          end else begin
            w_cnt_d    = w_start_wait;
            w_wait_n_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (cpu_rd_n_i) begin
          // Abort: nothing is latched, the bus keeps its floating value
          w_wait_n_d = 1'b1;
        end else if (r_cnt_q == c_cnt_one) begin
          w_di_d     = w_held_data;
          w_wait_n_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt_q - c_cnt_one;
        end
      end
      ST_HOLD: begin
        if (cpu_rd_n_i) w_di_d = DEFAULT_DATA;
      end
      default: begin
        w_di_d     = DEFAULT_DATA;
        w_wait_n_d = 1'b1;
      end
    endcase
  end

  assign cpu_di_o     = r_di_q;
  assign cpu_wait_n_o = r_wait_n_q;
  assign busy_o       = (r_state_q != ST_IDLE);
  assign active_ch_o  = r_ch_q;

`ifdef CPU_DI_COLLISION_DET_EN
  logic r_coll_q, w_coll_d;

  // Sticky collision: a new collision on the clear edge takes priority
  always_comb begin
    w_coll_d = r_coll_q;
    if (collision_clr_i) w_coll_d = 1'b0;
    if ((r_state_q == ST_IDLE) && w_start && w_multi) w_coll_d = 1'b1;
  end

  // Collision flag register
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) r_coll_q <= 1'b0;
    else            r_coll_q <= w_coll_d;
  end

  assign collision_o = r_coll_q;
`else
  logic w_unused_coll;
  assign w_unused_coll = collision_clr_i | w_multi;
  assign collision_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_di_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_di_mux_n
//  Brief    : Directed self-checking bench for cpu_di_mux_n (4 ch, 8-bit).
//             Collision expectations follow CPU_DI_COLLISION_DET_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_di_mux_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ch_data;
  logic [3:0]  ch_sel;
  logic [15:0] ch_wait;
  logic        rd_n;
  logic        coll_clr;
  logic [7:0]  cpu_di;
  logic        wait_n;
  logic        busy;
  logic [1:0]  active_ch;
  logic        collision;

  int errors = 0;
  int checks = 0;

`ifdef CPU_DI_COLLISION_DET_EN
  localparam logic COLL_EN = 1'b1;
`else
  localparam logic COLL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_di_mux_n #(
    .NUM_CH (4),
    .DATA_W (8),
    .WAIT_W (4)
  ) dut (
    .clock_i         (clk),
    .reset_n_i       (rst_n),
    .ch_data_i       (ch_data),
    .ch_sel_i        (ch_sel),
    .ch_wait_i       (ch_wait),
    .cpu_rd_n_i      (rd_n),
    .collision_clr_i (coll_clr),
    .cpu_di_o        (cpu_di),
    .cpu_wait_n_o    (wait_n),
    .busy_o          (busy),
    .active_ch_o     (active_ch),
    .collision_o     (collision)
  );

  // Advance one rising edge and settle before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coll_clr = 1'b0; rd_n = 1'b0; ch_sel = 4'b0010;
    ch_wait = 16'h0000; ch_data = 32'h0000_5A00;
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL reset_di: got %h expected ff", cpu_di); end
      checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n: got %b expected 1", wait_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    end
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b expected 0", collision); end
    rst_n = 1'b1;
    tick();
    checks++; if (cpu_di !== 8'h5A) begin errors++; $display("FAIL first_read_di: got %h expected 5a", cpu_di); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_read_busy: got %b expected 1", busy); end
    checks++; if (active_ch !== 2'd1) begin errors++; $display("FAIL first_read_ch: got %0d expected 1", active_ch); end
    rd_n = 1'b1;
    tick();
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL first_release_di: got %h expected ff", cpu_di); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_no_wait();
    ch_wait = 16'h0000; ch_data[7:0] = 8'h3E; ch_sel = 4'b0001; rd_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (cpu_di !== 8'h3E) begin errors++; $display("FAIL nowait_di: got %h expected 3e", cpu_di); end
      checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL nowait_wait_n: got %b expected 1", wait_n); end
    end
    rd_n = 1'b1;
    tick();
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL nowait_release_di: got %h expected ff", cpu_di); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nowait_release_busy: got %b expected 0", busy); end
  endtask

  // Count WAIT-low samples and the sample index at which data first appears
  task automatic run_wait(input int ch, input logic [3:0] w, input logic [7:0] d,
                          input int n, input string name, input int exp_lows, input int exp_first);
    int lows;
    int first;
    lows = 0; first = 0;
    ch_wait[ch*4 +: 4] = w; ch_data[ch*8 +: 8] = d;
    ch_sel = 4'b0001 << ch; rd_n = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (wait_n === 1'b0) lows++;
      if (first == 0 && cpu_di === d) first = k;
      if (k == 1) begin
        checks++; if (active_ch !== ch[1:0]) begin errors++; $display("FAIL %s_ch: got %0d expected %0d", name, active_ch, ch); end
      end
    end
    checks++; if (lows != exp_lows) begin errors++; $display("FAIL %s_lows: got %0d expected %0d", name, lows, exp_lows); end
    checks++; if (first != exp_first) begin errors++; $display("FAIL %s_first: got %0d expected %0d", name, first, exp_first); end
    rd_n = 1'b1;
    tick();
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL %s_release_di: got %h expected ff", name, cpu_di); end
  endtask

  task automatic test_wait_states();
    run_wait(2, 4'd3, 8'hA5, 6, "wait3", 3, 4);
    run_wait(3, 4'd15, 8'h9C, 20, "wait15", 15, 16);
  endtask

  task automatic test_abort();
    ch_wait[7:4] = 4'd5; ch_data[15:8] = 8'h77; ch_sel = 4'b0010; rd_n = 1'b0;
    tick();
    checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL abort_wait_low: got %b expected 0", wait_n); end
    tick();
    tick();
    rd_n = 1'b1;
    tick();
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL abort_wait_n: got %b expected 1", wait_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL abort_di: got %h expected ff", cpu_di); end
    tick();
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL abort_idle_di: got %h expected ff", cpu_di); end
  endtask

  task automatic test_hold();
    ch_wait = 16'h0000; ch_data[7:0] = 8'h11; ch_sel = 4'b0001; rd_n = 1'b0;
    tick();
    checks++; if (cpu_di !== 8'h11) begin errors++; $display("FAIL hold_capture: got %h expected 11", cpu_di); end
    ch_data[7:0] = 8'h22; ch_sel = 4'b0000;
    tick();
    tick();
    checks++; if (cpu_di !== 8'h11) begin errors++; $display("FAIL hold_stable: got %h expected 11", cpu_di); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b expected 1", busy); end
    rd_n = 1'b1;
    tick();
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL hold_release: got %h expected ff", cpu_di); end
  endtask

  task automatic test_no_select();
    ch_sel = 4'b0000; rd_n = 1'b0;
    tick();
    tick();
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL nosel_di: got %h expected ff", cpu_di); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nosel_busy: got %b expected 0", busy); end
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL nosel_wait_n: got %b expected 1", wait_n); end
    rd_n = 1'b1;
    tick();
  endtask

  task automatic test_collision();
    ch_wait = 16'h0000; ch_data[15:8] = 8'hC3; ch_sel = 4'b0110; rd_n = 1'b0;
    tick();
    checks++; if (active_ch !== 2'd1) begin errors++; $display("FAIL coll_grant: got %0d expected 1", active_ch); end
    checks++; if (cpu_di !== 8'hC3) begin errors++; $display("FAIL coll_di: got %h expected c3", cpu_di); end
    checks++; if (collision !== COLL_EN) begin errors++; $display("FAIL coll_set: got %b expected %b", collision, COLL_EN); end
    rd_n = 1'b1; ch_sel = 4'b0000;
    tick();
    tick();
    checks++; if (collision !== COLL_EN) begin errors++; $display("FAIL coll_sticky: got %b expected %b", collision, COLL_EN); end
    coll_clr = 1'b1;
    tick();
    coll_clr = 1'b0;
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b expected 0", collision); end
    ch_sel = 4'b0110; rd_n = 1'b0; coll_clr = 1'b1;
    tick();
    coll_clr = 1'b0;
    checks++; if (collision !== COLL_EN) begin errors++; $display("FAIL coll_set_wins: got %b expected %b", collision, COLL_EN); end
    rd_n = 1'b1; ch_sel = 4'b0000; coll_clr = 1'b1;
    tick();
    coll_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    ch_wait = 16'h0000; ch_data[7:0] = 8'h3E; ch_sel = 4'b0001; rd_n = 1'b0;
    tick();
    checks++; if (cpu_di !== 8'h3E) begin errors++; $display("FAIL b2b_first_di: got %h expected 3e", cpu_di); end
    rd_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b expected 0", busy); end
    ch_wait[11:8] = 4'd1; ch_data[23:16] = 8'hA5; ch_sel = 4'b0100; rd_n = 1'b0;
    tick();
    checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL b2b_wait_low: got %b expected 0", wait_n); end
    checks++; if (active_ch !== 2'd2) begin errors++; $display("FAIL b2b_ch: got %0d expected 2", active_ch); end
    tick();
    checks++; if (cpu_di !== 8'hA5) begin errors++; $display("FAIL b2b_second_di: got %h expected a5", cpu_di); end
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL b2b_wait_rel: got %b expected 1", wait_n); end
    rd_n = 1'b1;
    tick();
  endtask

  task automatic test_mid_reset();
    ch_wait[11:8] = 4'd3; ch_sel = 4'b0100; rd_n = 1'b0;
    tick();
    tick();
    checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL midrst_pre_wait: got %b expected 0", wait_n); end
    rst_n = 1'b0;
    #1;
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL midrst_wait_n: got %b expected 1", wait_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL midrst_ch: got %0d expected 0", active_ch); end
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL midrst_di: got %h expected ff", cpu_di); end
    rd_n = 1'b1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_no_wait();
    test_wait_states();
    test_abort();
    test_hold();
    test_no_select();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
